// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//   Turns a raw, bouncing button/switch level into a clean clk-synchronous
//   level for the downstream one-shot trigger.
//
//   Signal path:
//     btn_i -> two-flop synchronizer -> 4-state qualify FSM with a stability
//     counter -> registered btn_o / busy_o.
//
//   Optional feature:
//     Define DEBOUNCE_CNT_EN to add press_cnt[7:0]. This 8-bit count of
//     qualified presses goes up by one on every CHK_H -> HIGH transition and
//     wraps from 255 to 0.
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int STABLE_CNT = 4,   // cycles btn_s must hold before btn_o follows (>= 2)
  parameter int CNT_W      = 16   // must be wide enough to hold STABLE_CNT-1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_i,
  output logic       btn_o,
  output logic       busy_o
`ifdef DEBOUNCE_CNT_EN
  ,
  output logic [7:0] press_cnt
`endif
);

  typedef enum logic [1:0] {
    LOW   = 2'b00,
    CHK_H = 2'b01,
    HIGH  = 2'b10,
    CHK_L = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

  logic [1:0]       sync_q, sync_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;
  logic             busy_q, busy_d;
  logic             btn_s;

  // After the two synchronizer flops, the synchronized level is the only
  // version of the button that the rest of the logic sees.
  assign btn_s = sync_q[1];

  // Synchronizer shift: sync[0] samples btn_i, and sync[1] samples sync[0].
  always_comb begin
    sync_d = {sync_q[0], btn_i};
  end

  // Qualify FSM: a change at btn_s is accepted only after it has held for
  // STABLE_CNT cycles. Any reversal returns to the previous stable state.
  always_comb begin
    // NOTE: every variable gets a default before the case. Otherwise a path
    // that does not assign a variable would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOW: begin
        if (btn_s) begin
          state_d = CHK_H;
          cnt_d   = '0;
        end
      end
      CHK_H: begin
        if (!btn_s) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!btn_s) begin
          state_d = CHK_L;
          cnt_d   = '0;
        end
      end
      CHK_L: begin
        if (btn_s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state, so the registered values line
  // up with the state register and no path exists from btn_i to an output.
  always_comb begin
    btn_d  = (state_d == HIGH)  || (state_d == CHK_L);
    busy_d = (state_d == CHK_H) || (state_d == CHK_L);
  end

  // State, counter, synchronizer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. All flops then
    // update together at the edge, and read order inside the block does not
    // matter.
    if (rst) begin
      sync_q  <= '0;
      state_q <= LOW;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      busy_q  <= busy_d;
    end
  end

  assign btn_o  = btn_q;
  assign busy_o = busy_q;

`ifdef DEBOUNCE_CNT_EN
  logic [7:0] press_cnt_q, press_cnt_d;

  // Count each qualified press once, at the moment it is accepted. The
  // count wraps naturally from 255 to 0.
  always_comb begin
    press_cnt_d = press_cnt_q;
    if (state_q == CHK_H && state_d == HIGH) begin
      press_cnt_d = press_cnt_q + 8'd1;
    end
  end

  // Press counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_cnt_q <= '0;
    end else begin
      press_cnt_q <= press_cnt_d;
    end
  end

  assign press_cnt = press_cnt_q;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce
//   Directed bench for btn_debounce with STABLE_CNT = 4.
//
//   Timing convention: inputs change 1 ns after a rising edge. The next
//   rising edge ("edge k") is the first one that samples the new value.
//   After tick(n), the bench sits 1 ns past edge k+n-1.
//
//   With this convention, btn_o follows a held change on edge k+6, which
//   is the 7th tick.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_i;
  logic       btn_o;
  logic       busy_o;
`ifdef DEBOUNCE_CNT_EN
  logic [7:0] press_cnt;
`endif

  int total = 0;
  int bad   = 0;

  btn_debounce #(.STABLE_CNT(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_i     (btn_i),
    .btn_o     (btn_o),
    .busy_o    (busy_o)
`ifdef DEBOUNCE_CNT_EN
    ,
    .press_cnt (press_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance n rising edges and then settle 1 ns past the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold reset for two cycles with the button pressed. After release, the
  // press must be qualified again from scratch.
  task automatic test_reset;
    rst   = 1'b1;
    btn_i = 1'b1;
    tick(2);
    total++;
    if (btn_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: btn_o=%b busy_o=%b want 0 0", btn_o, busy_o);
    end
`ifdef DEBOUNCE_CNT_EN
    total++;
    if (press_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_cnt: press_cnt=%0d want 0", press_cnt);
    end
`endif
    rst = 1'b0;
    tick(6);                       // now past edge k+5
    total++;
    if (btn_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_rise_early: btn_o=%b want 0", btn_o);
    end
    tick(1);                       // now past edge k+6
    total++;
    if (btn_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_rise: btn_o=%b busy_o=%b want 1 0", btn_o, busy_o);
    end
  endtask

  // Release the button, then make a clean press and check the latency.
  task automatic test_press;
    btn_i = 1'b0;
    tick(10);
    total++;
    if (btn_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL press_idle: btn_o=%b busy_o=%b want 0 0", btn_o, busy_o);
    end
    btn_i = 1'b1;
    tick(4);                       // past edge k+3
    total++;
    if (busy_o !== 1'b1 || btn_o !== 1'b0) begin
      bad++;
      $display("FAIL press_busy: busy_o=%b btn_o=%b want 1 0", busy_o, btn_o);
    end
    tick(2);                       // past edge k+5
    total++;
    if (btn_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL press_early: btn_o=%b busy_o=%b want 0 1", btn_o, busy_o);
    end
    tick(1);                       // past edge k+6
    total++;
    if (btn_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL press_rise: btn_o=%b busy_o=%b want 1 0", btn_o, busy_o);
    end
  endtask

  // A 3-cycle high pulse is too short to qualify, so it must be rejected.
  task automatic test_bounce;
`ifdef DEBOUNCE_CNT_EN
    logic [7:0] cnt_before;
`endif
    btn_i = 1'b0;
    tick(10);
`ifdef DEBOUNCE_CNT_EN
    cnt_before = press_cnt;
`endif
    btn_i = 1'b1;
    tick(3);                       // past edge k+2: qualification has begun
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL bounce_busy: busy_o=%b want 1", busy_o);
    end
    btn_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      total++;
      if (btn_o !== 1'b0) begin
        bad++;
        $display("FAIL bounce_hold[%0d]: btn_o=%b want 0", i, btn_o);
      end
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL bounce_low: busy_o=%b want 0", busy_o);
    end
`ifdef DEBOUNCE_CNT_EN
    total++;
    if (press_cnt !== cnt_before) begin
      bad++;
      $display("FAIL bounce_cnt: press_cnt=%0d want %0d", press_cnt, cnt_before);
    end
`endif
  endtask

  // While in HIGH, single-cycle low glitches must not drop btn_o.
  task automatic test_glitch_high;
    logic [4:0] pat;
    pat   = 5'b10101;              // applied LSB first: 1,0,1,0,1
    btn_i = 1'b1;
    tick(10);
    total++;
    if (btn_o !== 1'b1) begin
      bad++;
      $display("FAIL glitch_setup: btn_o=%b want 1", btn_o);
    end
    for (int i = 0; i < 5; i++) begin
      btn_i = pat[i];
      tick(1);
      total++;
      if (btn_o !== 1'b1) begin
        bad++;
        $display("FAIL glitch_toggle[%0d]: btn_o=%b want 1", i, btn_o);
      end
    end
    btn_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      total++;
      if (btn_o !== 1'b1) begin
        bad++;
        $display("FAIL glitch_after[%0d]: btn_o=%b want 1", i, btn_o);
      end
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL glitch_settle: busy_o=%b want 0", busy_o);
    end
  endtask

  // Releasing from HIGH has the same 6-edge latency as a press.
  task automatic test_release;
    btn_i = 1'b0;
    tick(6);                       // past edge j+5
    total++;
    if (btn_o !== 1'b1 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL release_early: btn_o=%b busy_o=%b want 1 1", btn_o, busy_o);
    end
    tick(1);                       // past edge j+6
    total++;
    if (btn_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL release_fall: btn_o=%b busy_o=%b want 0 0", btn_o, busy_o);
    end
  endtask

  // Reset in the middle of CHK_H abandons the qualification in progress.
  // With btn_i still high, the press must be qualified again from scratch.
  task automatic test_reset_mid_chk;
    btn_i = 1'b0;
    tick(10);
    btn_i = 1'b1;
    tick(4);                       // in CHK_H, counting
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL midrst_busy: busy_o=%b want 1", busy_o);
    end
    rst = 1'b1;
    tick(1);
    total++;
    if (btn_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL midrst_out: btn_o=%b busy_o=%b want 0 0", btn_o, busy_o);
    end
`ifdef DEBOUNCE_CNT_EN
    total++;
    if (press_cnt !== 8'd0) begin
      bad++;
      $display("FAIL midrst_cnt: press_cnt=%0d want 0", press_cnt);
    end
`endif
    rst = 1'b0;
    tick(6);
    total++;
    if (btn_o !== 1'b0) begin
      bad++;
      $display("FAIL midrst_requal_early: btn_o=%b want 0", btn_o);
    end
    tick(1);
    total++;
    if (btn_o !== 1'b1) begin
      bad++;
      $display("FAIL midrst_requal: btn_o=%b want 1", btn_o);
    end
  endtask

`ifdef DEBOUNCE_CNT_EN
  // After reset, 257 clean presses make the 8-bit count wrap to 1.
  task automatic test_press_cnt_wrap;
    rst   = 1'b1;
    btn_i = 1'b0;
    tick(2);
    rst = 1'b0;
    for (int p = 1; p <= 257; p++) begin
      btn_i = 1'b1;
      tick(9);
      btn_i = 1'b0;
      tick(9);
      if (p == 1 || p == 255 || p == 256) begin
        total++;
        if (press_cnt !== 8'(p)) begin
          bad++;
          $display("FAIL cnt_step[%0d]: press_cnt=%0d want %0d", p, press_cnt, 8'(p));
        end
      end
    end
    total++;
    if (press_cnt !== 8'd1 || btn_o !== 1'b0) begin
      bad++;
      $display("FAIL cnt_wrap: press_cnt=%0d btn_o=%b want 1 0", press_cnt, btn_o);
    end
  endtask
`endif

  initial begin
    rst   = 1'b1;
    btn_i = 1'b0;
    tick(1);
    test_reset();
    test_press();
    test_bounce();
    test_glitch_high();
    test_release();
    test_reset_mid_chk();
`ifdef DEBOUNCE_CNT_EN
    test_press_cnt_wrap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
